basic_ops: RTL and testbench
============================

# basic_ops

Elementary logic-operator block used as the reference gate primitive in the basic-operators simulation suite. It drives two combinational outputs, a buffered copy of `a` and the inverse of `b`, with no clock dependence. It also provides a registered bank of the six two-input Boolean operators and a saturating input-activity counter for clocked consumers.

## Interface
Parameters:
- `CNT_W`, default 8: width of the activity counter.

Ports:
- `clk`  input  1  single system clock; all registers update on its rising edge.
- `rst`  input  1  reset, asynchronous and active-high; clears all registered state.
- `a`  input  1  operand A.
- `b`  input  1  operand B.
- `buf_a`  output  1  combinational buffer of `a`.
- `not_b`  output  1  combinational inverse of `b`.
- `ops_q`  output  6  registered operator bank: bit5 AND, bit4 OR, bit3 XOR, bit2 NAND, bit1 NOR, bit0 XNOR of (`a`,`b`).
- `a_q`, `b_q`  output  1 each  registered samples of `a` and `b`.
- `act_cnt`  output  CNT_W  saturating count of clock cycles in which `a` or `b` differs from its previous registered sample.

## Operation
- `buf_a` = `a` and `not_b` = ~`b`, both purely combinational.
  - They are independent of `clk` and `rst`, including during reset.
  - They follow input changes within the same simulation timestep.
- Truth table for (`a`,`b`) → (`buf_a`,`not_b`):
  - 00 → 0,1
  - 01 → 0,0
  - 10 → 1,1
  - 11 → 1,0
- `ops_q` on each rising `clk` edge (not in reset) loads {a&b, a|b, a^b, ~(a&b), ~(a|b), ~(a^b)}.
- `a_q`/`b_q` on each rising `clk` edge load `a`/`b`.
- `act_cnt` increments by 1 on any rising edge where (`a` != `a_q`) or (`b` != `b_q`).
  - It saturates at 2^CNT_W-1 and never wraps.
  - A simultaneous change on both inputs counts once.
- No handshake. Every input is sampled every cycle.

## Timing
- Combinational outputs: zero-cycle latency.
- Registered outputs (`ops_q`, `a_q`, `b_q`): one-cycle latency from input to output.
- Reset values: `ops_q` = 6'b000000, `a_q` = 0, `b_q` = 0, `act_cnt` = 0.
  - The all-zero `ops_q` after reset is intentional, even though NAND/NOR/XNOR would evaluate to 1 for 00 inputs.
- Reset assertion clears all registers immediately, asynchronously and without waiting for a clock edge.
- Reset asserted mid-operation: registers clear at once; a pending increment on that edge is discarded.
- First clock edge after reset release:
  - `ops_q` reflects the current inputs.
  - `act_cnt` increments if either input is non-zero, since the comparison is against the cleared `a_q`/`b_q`.
- Inputs must be stable around the `clk` edge. The combinational path has no such requirement.

## Test plan
- Unclocked truth table: apply (a,b) = 00, 01, 10, 11, 1 time unit apart, `clk` idle, `rst` = 0 → (buf_a,not_b) = (0,1), (0,0), (1,1), (1,0).
- Combinational during reset: hold `rst` = 1, apply a=1, b=0 → buf_a = 1, not_b = 1 immediately; `ops_q` = 0 and `act_cnt` = 0.
- Registered operator bank: after reset, apply a=1, b=0 and clock once → ops_q = 6'b011100. Then apply a=1, b=1 and clock → ops_q = 6'b110001.
- Activity counter: from reset, sequence (a,b) = 00, 01, 01, 11, 00 over 5 edges → act_cnt = 0, 1, 1, 2, 3.
- Saturation with CNT_W = 2: toggle `a` every cycle for 6 cycles → act_cnt climbs to 3 and holds 3.
- Asynchronous reset mid-run: with act_cnt = 2, assert `rst` between clock edges → act_cnt, ops_q, a_q and b_q clear immediately, before the next edge.

Source files
------------

// File: rtl/basic_ops.sv
// Reference gate primitive: combinational buffer/inverter, a registered bank
// of the six two-input Boolean operators and a saturating input-activity counter.
module basic_ops #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  output logic             buf_a,
  output logic             not_b,
  output logic [5:0]       ops_q,
  output logic             a_q,
  output logic             b_q,
  output logic [CNT_W-1:0] act_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic       activity;
  logic       cnt_sat;
  logic [5:0] ops_d;

  assign buf_a = a;
  assign not_b = ~b;

  // Bit order: AND, OR, XOR, NAND, NOR, XNOR (msb to lsb)
  assign ops_d = {a & b, a | b, a ^ b, ~(a & b), ~(a | b), ~(a ^ b)};

  assign activity = (a != a_q) || (b != b_q);
  assign cnt_sat  = (act_cnt == CNT_MAX);

  // Reset clears ops_q to all zeros on purpose, not to the 00-input operator values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ops_q   <= 6'b000000;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      act_cnt <= '0;
    end else begin
      ops_q <= ops_d;
      a_q   <= a;
      b_q   <= b;
      if (activity && !cnt_sat) begin
        act_cnt <= act_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_basic_ops.sv
// Directed self-checking bench for basic_ops: unclocked truth table, reset
// behaviour, operator bank, activity counter and saturation at CNT_W = 2.
module tb_basic_ops;

  logic       clk;
  logic       clk_run;
  logic       rst;
  logic       a, b;
  logic       sa, sb;

  logic       buf_a, not_b, a_q, b_q;
  logic [5:0] ops_q;
  logic [7:0] act_cnt;

  logic       s_buf_a, s_not_b, s_a_q, s_b_q;
  logic [5:0] s_ops_q;
  logic [1:0] s_act_cnt;

  int checks;
  int errors;

  basic_ops #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b),
    .buf_a(buf_a), .not_b(not_b), .ops_q(ops_q),
    .a_q(a_q), .b_q(b_q), .act_cnt(act_cnt)
  );

  basic_ops #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .a(sa), .b(sb),
    .buf_a(s_buf_a), .not_b(s_not_b), .ops_q(s_ops_q),
    .a_q(s_a_q), .b_q(s_b_q), .act_cnt(s_act_cnt)
  );

  initial clk = 1'b0;
  always #5 if (clk_run) clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic x, input logic y);
    @(negedge clk);
    a = x;
    b = y;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    a = 1'b0; b = 1'b0; sa = 1'b0; sb = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [1:0] seq_ab  [5];
    logic [7:0] seq_cnt [5];
    logic [1:0] sat_exp [6];
    logic [1:0] tt_exp  [4];

    checks = 0;
    errors = 0;
    clk_run = 1'b0;
    rst = 1'b1;
    a = 1'b0; b = 1'b0; sa = 1'b0; sb = 1'b0;
    #1;
    chk("reset_ops_q", ops_q, 6'b000000);
    chk("reset_a_q", a_q, 1'b0);
    chk("reset_b_q", b_q, 1'b0);
    chk("reset_act_cnt", act_cnt, 8'd0);

    // Unclocked truth table, rst low, clk idle
    rst = 1'b0;
    tt_exp = '{2'b01, 2'b00, 2'b11, 2'b10};
    for (int i = 0; i < 4; i++) begin
      a = i[1];
      b = i[0];
      #1;
      chk($sformatf("truth_%0d%0d", i[1], i[0]), {buf_a, not_b}, tt_exp[i]);
    end

    // Combinational path during reset
    rst = 1'b1;
    a = 1'b1; b = 1'b0;
    #1;
    chk("rst_buf_a", buf_a, 1'b1);
    chk("rst_not_b", not_b, 1'b1);
    chk("rst_ops_q", ops_q, 6'b000000);
    chk("rst_act_cnt", act_cnt, 8'd0);

    clk_run = 1'b1;
    do_reset();

    // Operator bank
    drive(1'b1, 1'b0);
    tick();
    chk("ops_10", ops_q, 6'b011100);
    chk("a_q_10", a_q, 1'b1);
    chk("b_q_10", b_q, 1'b0);
    chk("cnt_after_10", act_cnt, 8'd1);
    drive(1'b1, 1'b1);
    tick();
    chk("ops_11", ops_q, 6'b110001);
    chk("b_q_11", b_q, 1'b1);
    chk("cnt_after_11", act_cnt, 8'd2);

    // Activity counter sequence
    do_reset();
    seq_ab  = '{2'b00, 2'b01, 2'b01, 2'b11, 2'b00};
    seq_cnt = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3};
    for (int i = 0; i < 5; i++) begin
      drive(seq_ab[i][1], seq_ab[i][0]);
      tick();
      chk($sformatf("act_seq_%0d", i), act_cnt, seq_cnt[i]);
    end

    // Asynchronous reset between edges with act_cnt = 2
    do_reset();
    drive(1'b0, 1'b1);
    tick();
    drive(1'b1, 1'b1);
    tick();
    chk("pre_async_cnt", act_cnt, 8'd2);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_act_cnt", act_cnt, 8'd0);
    chk("async_ops_q", ops_q, 6'b000000);
    chk("async_a_q", a_q, 1'b0);
    chk("async_b_q", b_q, 1'b0);
    chk("async_buf_a", buf_a, 1'b1);

    // Saturation on the CNT_W = 2 instance
    do_reset();
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      sa = ~sa;
      tick();
      chk($sformatf("sat_%0d", i), s_act_cnt, sat_exp[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
